// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet TX arbiter.
package eth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GNT_ARP,
        GNT_UDP,
        IFG
    } state_t;

    localparam int CLI_ARP = 0;
    localparam int CLI_UDP = 1;

    localparam int IFG_DEFAULT     = 12;
    localparam int TIMEOUT_DEFAULT = 4096;

    function automatic int cnt_width(input int a, input int b);
        return $clog2(a > b ? a : b) + 1;
    endfunction

endpackage

// File: rtl/eth_tx_arb_cnt.sv
// Loadable saturating down-counter used for IFG and grant timeout.
module eth_tx_arb_cnt
    import eth_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/eth_tx_arb.sv
// Two-client GMII transmit arbiter with IFG enforcement and grant timeout.
// Define ETH_TX_ARB_RR_EN for round-robin ties; default is fixed ARP priority.
module eth_tx_arb
    import eth_pkg::*;
#(
    parameter int IFG_CYCLES     = IFG_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arp_req,
    output logic       arp_gnt,
    input  logic       arp_tx_en,
    input  logic [7:0] arp_txd,
    input  logic       arp_done,
    input  logic       udp_req,
    output logic       udp_gnt,
    input  logic       udp_tx_en,
    input  logic [7:0] udp_txd,
    input  logic       udp_done,
    output logic       gmii_tx_en,
    output logic [7:0] gmii_txd,
    output logic       busy,
    output logic       timeout_err
);

    localparam int CW = cnt_width(IFG_CYCLES, TIMEOUT_CYCLES);
    localparam logic [CW-1:0] IFG_LOAD = CW'(IFG_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LOAD = CW'(TIMEOUT_CYCLES - 1);

    state_t     state;
    logic [1:0] req_vec;
    logic       arp_win;
    logic       ifg_load;
    logic       ifg_zero;
    logic       tmo_load;
    logic       tmo_zero;

    assign req_vec[CLI_ARP] = arp_req;
    assign req_vec[CLI_UDP] = udp_req;

`ifdef ETH_TX_ARB_RR_EN
    logic last;

    assign arp_win = req_vec[CLI_ARP] &&
                     (!req_vec[CLI_UDP] || last == 1'(CLI_UDP));
`else
    assign arp_win = req_vec[CLI_ARP];
`endif

    // IFG restarts while the final byte is still on the wire
    assign ifg_load = (state != IFG) || gmii_tx_en;
    assign tmo_load = (state == IDLE);

    eth_tx_arb_cnt #(.W(CW)) u_ifg_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (ifg_load),
        .value (IFG_LOAD),
        .zero  (ifg_zero)
    );

    eth_tx_arb_cnt #(.W(CW)) u_tmo_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (tmo_load),
        .value (TMO_LOAD),
        .zero  (tmo_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            arp_gnt     <= 1'b0;
            udp_gnt     <= 1'b0;
            gmii_tx_en  <= 1'b0;
            gmii_txd    <= 8'h00;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
`ifdef ETH_TX_ARB_RR_EN
            last        <= 1'(CLI_UDP);
`endif
        end else begin
            timeout_err <= 1'b0;
            gmii_tx_en  <= 1'b0;
            gmii_txd    <= 8'h00;
            unique case (state)
                IDLE: begin
                    if (arp_win) begin
                        state   <= GNT_ARP;
                        arp_gnt <= 1'b1;
                        busy    <= 1'b1;
`ifdef ETH_TX_ARB_RR_EN
                        last    <= 1'(CLI_ARP);
`endif
                    end else if (req_vec[CLI_UDP]) begin
                        state   <= GNT_UDP;
                        udp_gnt <= 1'b1;
                        busy    <= 1'b1;
`ifdef ETH_TX_ARB_RR_EN
                        last    <= 1'(CLI_UDP);
`endif
                    end
                end
                GNT_ARP: begin
                    gmii_tx_en <= arp_tx_en;
                    gmii_txd   <= arp_txd;
                    if (arp_done || tmo_zero) begin
                        state       <= IFG;
                        arp_gnt     <= 1'b0;
                        timeout_err <= ~arp_done;
                    end
                end
                GNT_UDP: begin
                    gmii_tx_en <= udp_tx_en;
                    gmii_txd   <= udp_txd;
                    if (udp_done || tmo_zero) begin
                        state       <= IFG;
                        udp_gnt     <= 1'b0;
                        timeout_err <= ~udp_done;
                    end
                end
                IFG: begin
                    if (ifg_zero && !gmii_tx_en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_arb.sv
// Directed and random stimulus for eth_tx_arb against a cycle-number based
// reference model of grants, GMII mirroring, IFG spacing and timeout.
module tb_eth_tx_arb;

    localparam int IFG = 12;
    localparam int TMO = 48;
`ifdef ETH_TX_ARB_RR_EN
    localparam int TIE2 = 2;
`else
    localparam int TIE2 = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       arp_req, arp_gnt, arp_tx_en, arp_done;
    logic [7:0] arp_txd;
    logic       udp_req, udp_gnt, udp_tx_en, udp_done;
    logic [7:0] udp_txd;
    logic       gmii_tx_en;
    logic [7:0] gmii_txd;
    logic       busy;
    logic       timeout_err;

    int passed, failed, total;
    int cyc, owner, idle_from, gnt_cyc, last_cli, last_tx, aa_seen;
    int left[3];
    logic was[3];

    eth_tx_arb #(
        .IFG_CYCLES     (IFG),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .arp_req     (arp_req),
        .arp_gnt     (arp_gnt),
        .arp_tx_en   (arp_tx_en),
        .arp_txd     (arp_txd),
        .arp_done    (arp_done),
        .udp_req     (udp_req),
        .udp_gnt     (udp_gnt),
        .udp_tx_en   (udp_tx_en),
        .udp_txd     (udp_txd),
        .udp_done    (udp_done),
        .gmii_tx_en  (gmii_tx_en),
        .gmii_txd    (gmii_txd),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #4 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [7:0] rbyte();
        logic [7:0] b;
        b = 8'($urandom);
        return (b == 8'hAA) ? 8'h55 : b;
    endfunction

    // Model: owner 0/1/2 = none/ARP/UDP; idle_from = first IDLE cycle
    task automatic tick();
        logic       e_en, e_tmo, dn;
        logic [7:0] e_d;
        int         nc, pick;
        nc = cyc + 1;
        e_en = 1'b0;
        e_d = 8'h00;
        e_tmo = 1'b0;
        dn = 1'b0;
        if (rst) begin
            owner = 0;
            idle_from = nc;
            last_cli = 2;
        end else if (owner != 0) begin
            e_en = (owner == 1) ? arp_tx_en : udp_tx_en;
            e_d  = (owner == 1) ? arp_txd : udp_txd;
            dn   = (owner == 1) ? arp_done : udp_done;
            if (dn || nc - gnt_cyc == TMO) begin
                e_tmo = !dn;
                owner = 0;
                idle_from = nc + (e_en ? 1 : 0) + IFG;
            end
        end else if (cyc >= idle_from) begin
            pick = arp_req ? 1 : (udp_req ? 2 : 0);
`ifdef ETH_TX_ARB_RR_EN
            if (arp_req && udp_req && last_cli == 1) pick = 2;
`endif
            if (pick != 0) begin
                owner = pick;
                gnt_cyc = nc;
                last_cli = pick;
            end
        end
        @(posedge clk);
        #1;
        cyc = nc;
        chk("arp_gnt", 16'(arp_gnt), 16'(owner == 1));
        chk("udp_gnt", 16'(udp_gnt), 16'(owner == 2));
        chk("gmii_tx_en", 16'(gmii_tx_en), 16'(e_en));
        chk("gmii_txd", 16'(gmii_txd), 16'(e_d));
        chk("timeout_err", 16'(timeout_err), 16'(e_tmo));
        chk("busy", 16'(busy), 16'(owner != 0 || nc < idle_from));
        if (gmii_tx_en === 1'b1) last_tx = cyc;
        if (gmii_txd === 8'hAA) aa_seen++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_req(input int c, input logic v);
        if (c == 1) arp_req = v;
        else udp_req = v;
    endtask

    task automatic set_tx(input int c, input logic en,
                          input logic [7:0] d, input logic dn);
        if (c == 1) begin
            arp_tx_en = en;
            arp_txd = d;
            arp_done = dn;
        end else begin
            udp_tx_en = en;
            udp_txd = d;
            udp_done = dn;
        end
    endtask

    task automatic wait_owner(input int c, input int budget);
        int k;
        k = 0;
        while (owner != c && k < budget) begin
            tick();
            k++;
        end
        chk("wait_owner", 16'(owner), 16'(c));
    endtask

    // mid: 2 = raise udp_req halfway, 3 = stray arp_done halfway
    task automatic send(input int c, input int n, input int mid);
        for (int i = 0; i < n; i++) begin
            set_tx(c, 1'b1, rbyte(), i == n - 1);
            if (mid == 2 && i == n / 2) set_req(2, 1'b1);
            if (mid == 3) arp_done = (i == n / 2);
            tick();
        end
        set_tx(c, 1'b0, 8'h00, 1'b0);
        set_req(c, 1'b0);
        if (mid == 3) arp_done = 1'b0;
    endtask

    task automatic rnd_cli(input int c);
        logic r, en, dn;
        r = (c == 1) ? arp_req : udp_req;
        en = ($urandom_range(0, 3) == 0);
        dn = ($urandom_range(0, 15) == 0);
        if (owner == c) begin
            if (left[c] == 0) left[c] = int'($urandom_range(1, 60));
            en = ($urandom_range(0, 7) != 0);
            left[c]--;
            dn = (left[c] == 0);
            was[c] = 1'b1;
        end else if (was[c]) begin
            r = 1'b0;
            was[c] = 1'b0;
            left[c] = 0;
        end else if (!r && $urandom_range(0, 7) == 0) begin
            r = 1'b1;
        end else if (r && $urandom_range(0, 63) == 0) begin
            r = 1'b0;
        end
        set_req(c, r);
        set_tx(c, en, 8'($urandom), dn);
    endtask

    initial begin
        int k, g, w, c;
        passed = 0; failed = 0; total = 0;
        cyc = 0; owner = 0; idle_from = 0; gnt_cyc = 0;
        last_cli = 2; last_tx = 0; aa_seen = 0;
        for (int i = 0; i < 3; i++) begin
            left[i] = 0;
            was[i] = 1'b0;
        end
        rst = 1'b1;
        arp_req = 1'b0; udp_req = 1'b0;
        set_tx(1, 1'b0, 8'h00, 1'b0);
        set_tx(2, 1'b0, 8'h00, 1'b0);
        idle(2);
        rst = 1'b0;
        idle(2);

        // single ARP frame of 42 bytes
        set_req(1, 1'b1);
        tick();
        chk("arp_gnt_lat", 16'(arp_gnt), 16'(1));
        send(1, 42, 0);
        k = 0;
        while (busy === 1'b1 && k < 40) begin
            tick();
            k++;
        end
        chk("busy_fall", 16'(k), 16'(13));
        idle(3);

        // simultaneous requests, back to back
        set_req(1, 1'b1);
        set_req(2, 1'b1);
        tick();
        w = arp_gnt ? 1 : (udp_gnt ? 2 : 0);
        chk("tie_first", 16'(w), 16'(1));
        c = owner;
        send(c, int'($urandom_range(5, 20)), 0);
        set_req(c, 1'b1);
        k = 0;
        while (owner == 0 && k < 40) begin
            tick();
            k++;
        end
        w = arp_gnt ? 1 : (udp_gnt ? 2 : 0);
        chk("tie_second", 16'(w), 16'(TIE2));
        c = owner;
        send(c, int'($urandom_range(5, 20)), 0);
        k = 0;
        while (owner == 0 && k < 40) begin
            tick();
            k++;
        end
        c = owner;
        send(c, int'($urandom_range(5, 20)), 0);
        idle(20);

        // UDP request during ARP frame waits out IFG plus one IDLE cycle
        set_req(1, 1'b1);
        wait_owner(1, 5);
        send(1, 20, 2);
        k = 0;
        while (udp_gnt !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        chk("ifg_gap", 16'(cyc - last_tx - 1), 16'(13));
        send(2, 12, 0);
        idle(20);

        // UDP holds grant without done; then a withdrawn ARP request
        set_req(2, 1'b1);
        wait_owner(2, 5);
        g = cyc;
        k = 0;
        while (timeout_err !== 1'b1 && k < 80) begin
            set_tx(2, k < 5, rbyte(), 1'b0);
            tick();
            k++;
        end
        chk("tmo_cyc", 16'(cyc - g), 16'(TMO));
        chk("tmo_gnt", 16'(udp_gnt), 16'(0));
        set_tx(2, 1'b0, 8'h00, 1'b0);
        set_req(2, 1'b0);
        set_req(1, 1'b1);
        idle(3);
        set_req(1, 1'b0);
        idle(20);

        // reset mid UDP frame with ARP pending
        set_req(2, 1'b1);
        wait_owner(2, 5);
        set_req(1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            set_tx(2, 1'b1, rbyte(), 1'b0);
            tick();
        end
        rst = 1'b1;
        tick();
        chk("rst_tx_en", 16'(gmii_tx_en), 16'(0));
        chk("rst_gnt", 16'({arp_gnt, udp_gnt}), 16'(0));
        rst = 1'b0;
        set_tx(2, 1'b0, 8'h00, 1'b0);
        set_req(2, 1'b0);
        tick();
        chk("rst_regrant", 16'(arp_gnt), 16'(1));
        send(1, 15, 0);
        idle(20);

        // ARP noise and stray done during a UDP frame
        arp_tx_en = 1'b1;
        arp_txd = 8'hAA;
        aa_seen = 0;
        set_req(2, 1'b1);
        wait_owner(2, 5);
        send(2, 30, 3);
        arp_tx_en = 1'b0;
        arp_txd = 8'h00;
        idle(15);
        chk("no_aa", 16'(aa_seen), 16'(0));

        // random traffic, noise and occasional reset
        for (int i = 0; i < 1500; i++) begin
            rnd_cli(1);
            rnd_cli(2);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        set_req(1, 1'b0);
        set_req(2, 1'b0);
        set_tx(1, 1'b0, 8'h00, 1'b0);
        set_tx(2, 1'b0, 8'h00, 1'b0);
        idle(80);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
